// File: rtl/sha_compressor_unrolled.sv
`default_nettype none
// ============================================================================
// sha_compressor_unrolled: SHA-256 compression running ROUNDS_PER_CYCLE rounds
// per clock with valid/ready start, message-word and result handshakes. Rev 1.0
// ============================================================================
module sha_compressor_unrolled #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit FEEDFORWARD      = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_valid,
    output logic                            start_ready,
    input  logic [255:0]                    inputhashstate,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic [32*ROUNDS_PER_CYCLE-1:0]  W,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [255:0]                    hash,
    output logic [5:0]                      round_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
        $error("sha_compressor_unrolled: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [5:0] RPC_STEP   = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] LAST_ROUND = 6'(64 - ROUNDS_PER_CYCLE);

    function automatic logic [31:0] k_const(input logic [5:0] idx);
        k_const = 32'h0;
        case (idx)
            6'd0 : k_const = 32'h428a2f98;
            6'd1 : k_const = 32'h71374491;
            6'd2 : k_const = 32'hb5c0fbcf;
            6'd3 : k_const = 32'he9b5dba5;
            6'd4 : k_const = 32'h3956c25b;
            6'd5 : k_const = 32'h59f111f1;
            6'd6 : k_const = 32'h923f82a4;
            6'd7 : k_const = 32'hab1c5ed5;
            6'd8 : k_const = 32'hd807aa98;
            6'd9 : k_const = 32'h12835b01;
            6'd10: k_const = 32'h243185be;
            6'd11: k_const = 32'h550c7dc3;
            6'd12: k_const = 32'h72be5d74;
            6'd13: k_const = 32'h80deb1fe;
            6'd14: k_const = 32'h9bdc06a7;
            6'd15: k_const = 32'hc19bf174;
            6'd16: k_const = 32'he49b69c1;
            6'd17: k_const = 32'hefbe4786;
            6'd18: k_const = 32'h0fc19dc6;
            6'd19: k_const = 32'h240ca1cc;
            6'd20: k_const = 32'h2de92c6f;
            6'd21: k_const = 32'h4a7484aa;
            6'd22: k_const = 32'h5cb0a9dc;
            6'd23: k_const = 32'h76f988da;
            6'd24: k_const = 32'h983e5152;
            6'd25: k_const = 32'ha831c66d;
            6'd26: k_const = 32'hb00327c8;
            6'd27: k_const = 32'hbf597fc7;
            6'd28: k_const = 32'hc6e00bf3;
            6'd29: k_const = 32'hd5a79147;
            6'd30: k_const = 32'h06ca6351;
            6'd31: k_const = 32'h14292967;
            6'd32: k_const = 32'h27b70a85;
            6'd33: k_const = 32'h2e1b2138;
            6'd34: k_const = 32'h4d2c6dfc;
            6'd35: k_const = 32'h53380d13;
            6'd36: k_const = 32'h650a7354;
            6'd37: k_const = 32'h766a0abb;
            6'd38: k_const = 32'h81c2c92e;
            6'd39: k_const = 32'h92722c85;
            6'd40: k_const = 32'ha2bfe8a1;
            6'd41: k_const = 32'ha81a664b;
            6'd42: k_const = 32'hc24b8b70;
            6'd43: k_const = 32'hc76c51a3;
            6'd44: k_const = 32'hd192e819;
            6'd45: k_const = 32'hd6990624;
            6'd46: k_const = 32'hf40e3585;
            6'd47: k_const = 32'h106aa070;
            6'd48: k_const = 32'h19a4c116;
            6'd49: k_const = 32'h1e376c08;
            6'd50: k_const = 32'h2748774c;
            6'd51: k_const = 32'h34b0bcb5;
            6'd52: k_const = 32'h391c0cb3;
            6'd53: k_const = 32'h4ed8aa4a;
            6'd54: k_const = 32'h5b9cca4f;
            6'd55: k_const = 32'h682e6ff3;
            6'd56: k_const = 32'h748f82ee;
            6'd57: k_const = 32'h78a5636f;
            6'd58: k_const = 32'h84c87814;
            6'd59: k_const = 32'h8cc70208;
            6'd60: k_const = 32'h90befffa;
            6'd61: k_const = 32'ha4506ceb;
            6'd62: k_const = 32'hbef9a3f7;
            6'd63: k_const = 32'hc67178f2;
        endcase
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // State word order is {a,b,c,d,e,f,g,h}, a in the most significant word.
    function automatic logic [255:0] sha_round(input logic [255:0] s,
                                               input logic [31:0]  k,
                                               input logic [31:0]  w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    state_t        state_q;
    logic [255:0]  work_q;
    logic [255:0]  init_q;
    logic [255:0]  hash_q;
    logic [5:0]    round_q;
    logic [255:0]  work_d;
    logic [255:0]  hash_d;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_lane
        logic [255:0] st_in;
        logic [255:0] st_out;
        if (j == 0) begin : g_first
            assign st_in = work_q;
        end else begin : g_chain
            assign st_in = g_lane[j-1].st_out;
        end
        // round_q is a multiple of ROUNDS_PER_CYCLE, so round_q + j never wraps.
        assign st_out = sha_round(st_in, k_const(round_q + 6'(j)), W[32*j +: 32]);
    end

    assign work_d = g_lane[ROUNDS_PER_CYCLE-1].st_out;

    if (FEEDFORWARD) begin : g_ff
        assign hash_d = add_words(work_d, init_q);
    end else begin : g_raw
        assign hash_d = work_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            init_q  <= '0;
            hash_q  <= '0;
            round_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        work_q  <= inputhashstate;
                        init_q  <= inputhashstate;
                        round_q <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_valid) begin
                        work_q  <= work_d;
                        round_q <= round_q + RPC_STEP;
                        if (round_q == LAST_ROUND) begin
                            hash_q  <= hash_d;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // start_ready equals out_ready here, so a new block can
                    // be taken in the same cycle the result is handed off.
                    if (out_ready) begin
                        if (start_valid) begin
                            work_q  <= inputhashstate;
                            init_q  <= inputhashstate;
                            round_q <= '0;
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign w_ready     = (state_q == S_RUN);
    assign out_valid   = (state_q == S_DONE);
    assign hash        = hash_q;
    assign round_idx   = round_q;

endmodule
`default_nettype wire

// File: tb/tb_sha_compressor_unrolled.sv
`default_nettype none
// ============================================================================
// tb_sha_compressor_unrolled: scoreboard bench for sha_compressor_unrolled.
// Revision: 1.0
// ============================================================================
module tb_sha_compressor_unrolled;

    localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam int               SW_N   = 5;
    localparam logic [4:0][3:0]  SW_RPC = {4'd8, 4'd8, 4'd4, 4'd2, 4'd1};
    localparam logic [4:0]       SW_FF  = 5'b01111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  wsched [2][64];
    logic [255:0] raw_abc;
    logic [255:0] exp_q [$];

    // main DUT: 2 rounds per clock, feed-forward on
    logic         start_valid, start_ready, w_valid, w_ready, out_valid, out_ready;
    logic [255:0] ihs, hash;
    logic [63:0]  w_main;
    logic [5:0]   round_idx;

    sha_compressor_unrolled #(.ROUNDS_PER_CYCLE(2), .FEEDFORWARD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready), .inputhashstate(ihs),
        .w_valid(w_valid), .w_ready(w_ready), .W(w_main),
        .out_valid(out_valid), .out_ready(out_ready),
        .hash(hash), .round_idx(round_idx)
    );

    // sweep instances driven in lockstep with "abc"
    logic         sw_start_valid, sw_w_valid, sw_out_ready;
    int           sw_grp;
    logic [4:0]   sw_sr, sw_wr, sw_ov;
    logic [5:0]   sw_ri   [SW_N];
    logic [255:0] sw_hash [SW_N];

    for (genvar i = 0; i < SW_N; i++) begin : g_sweep
        localparam int R = int'(SW_RPC[i]);
        logic [32*R-1:0] w_bus;
        logic            sr, wr, ov;
        logic [5:0]      ri;
        logic [255:0]    h;
        always_comb begin
            w_bus = '0;
            for (int j = 0; j < R; j++) begin
                if (sw_grp * R + j < 64) w_bus[32*j +: 32] = wsched[0][sw_grp * R + j];
            end
        end
        sha_compressor_unrolled #(.ROUNDS_PER_CYCLE(R), .FEEDFORWARD(SW_FF[i])) u_dut (
            .clk(clk), .rst_n(rst_n),
            .start_valid(sw_start_valid), .start_ready(sr), .inputhashstate(IV),
            .w_valid(sw_w_valid), .w_ready(wr), .W(w_bus),
            .out_valid(ov), .out_ready(sw_out_ready),
            .hash(h), .round_idx(ri)
        );
        assign sw_sr[i]   = sr;
        assign sw_wr[i]   = wr;
        assign sw_ov[i]   = ov;
        assign sw_ri[i]   = ri;
        assign sw_hash[i] = h;
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_schedules();
        for (int b = 0; b < 2; b++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) begin
                    if (b == 0) wsched[b][t] = (t == 0) ? 32'h61626380 : ((t == 15) ? 32'h00000018 : 32'h0);
                    else        wsched[b][t] = (t == 0) ? 32'h80000000 : 32'h0;
                end else begin
                    wsched[b][t] = (rr(wsched[b][t-2], 17) ^ rr(wsched[b][t-2], 19) ^ (wsched[b][t-2] >> 10))
                                 + wsched[b][t-7]
                                 + (rr(wsched[b][t-15], 7) ^ rr(wsched[b][t-15], 18) ^ (wsched[b][t-15] >> 3))
                                 + wsched[b][t-16];
                end
            end
        end
        for (int i = 0; i < 8; i++) raw_abc[32*i +: 32] = DIG_ABC[32*i +: 32] - IV[32*i +: 32];
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [255:0] exp);
        start_valid = 1'b1;
        ihs         = IV;
        exp_q.push_back(exp);
        step();
        start_valid = 1'b0;
    endtask

    task automatic feed_block(input int blk);
        for (int g = 0; g < 32; g++) begin
            w_valid = 1'b1;
            w_main  = {wsched[blk][2*g+1], wsched[blk][2*g]};
            step();
        end
        w_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
        n_tests++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL reset_w_ready: got %b expected 0", w_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (hash !== 256'h0) begin n_fail++; $display("FAIL reset_hash: got %h expected 0", hash); end
        n_tests++; if (round_idx !== 6'd0) begin n_fail++; $display("FAIL reset_round_idx: got %0d expected 0", round_idx); end
    endtask

    task automatic test_sweep();
        logic [255:0] exp;
        logic         eov;
        sw_start_valid = 1'b1;
        step();
        sw_start_valid = 1'b0;
        sw_w_valid     = 1'b1;
        sw_grp         = 0;
        for (int m = 1; m <= 66; m++) begin
            step();
            for (int i = 0; i < SW_N; i++) begin
                eov = (m >= 64 / int'(SW_RPC[i]));
                n_tests++;
                if (sw_ov[i] !== eov) begin
                    n_fail++;
                    $display("FAIL sweep_latency[%0d] cycle %0d: got out_valid %b expected %b", i, m, sw_ov[i], eov);
                end
            end
            sw_grp = m;
        end
        for (int i = 0; i < SW_N; i++) begin
            exp = SW_FF[i] ? DIG_ABC : raw_abc;
            n_tests++;
            if (sw_hash[i] !== exp) begin
                n_fail++;
                $display("FAIL sweep_hash[%0d]: got %h expected %h", i, sw_hash[i], exp);
            end
        end
        sw_out_ready = 1'b1;
        step();
        sw_out_ready = 1'b0;
        sw_w_valid   = 1'b0;
        for (int i = 0; i < SW_N; i++) begin
            n_tests++;
            if (sw_ov[i] !== 1'b0 || sw_sr[i] !== 1'b1 || sw_wr[i] !== 1'b0 || sw_ri[i] !== 6'd0) begin
                n_fail++;
                $display("FAIL sweep_idle[%0d]: got ov=%b sr=%b wr=%b ri=%0d expected 0 1 0 0",
                         i, sw_ov[i], sw_sr[i], sw_wr[i], sw_ri[i]);
            end
        end
    endtask

    task automatic test_abc_main();
        do_start(DIG_ABC);
        feed_block(0);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL abc_out_valid: got %b expected 1", out_valid); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL abc_scoreboard: got empty queue expected entry"); end
        else begin
            if (hash !== exp_q[0]) begin n_fail++; $display("FAIL abc_hash: got %h expected %h", hash, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abc_handoff: got out_valid %b expected 0", out_valid); end
        n_tests++; if (hash !== DIG_ABC) begin n_fail++; $display("FAIL abc_hash_kept: got %h expected %h", hash, DIG_ABC); end
    endtask

    task automatic test_stalls();
        int g;
        int idle;
        int budget;
        do_start(DIG_ABC);
        g = 0;
        budget = 1000;
        while (g < 32 && budget > 0) begin
            idle = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
            for (int k = 0; k < idle; k++) begin
                w_valid = 1'b0;
                w_main  = {$urandom, $urandom};
                step();
                budget--;
                n_tests++;
                if (round_idx !== 6'(2 * g) || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold: got round_idx %0d out_valid %b expected %0d 0", round_idx, out_valid, 6'(2 * g));
                end
            end
            w_valid = 1'b1;
            w_main  = {wsched[0][2*g+1], wsched[0][2*g]};
            step();
            budget--;
            g++;
            n_tests++;
            if (round_idx !== 6'(2 * g)) begin
                n_fail++;
                $display("FAIL stall_advance: got round_idx %0d expected %0d", round_idx, 6'(2 * g));
            end
        end
        w_valid = 1'b0;
        n_tests++; if (budget <= 0) begin n_fail++; $display("FAIL stall_budget: got %0d groups expected 32", g); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b expected 1", out_valid); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stall_scoreboard: got empty queue expected entry"); end
        else begin
            if (hash !== exp_q[0]) begin n_fail++; $display("FAIL stall_hash: got %h expected %h", hash, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        do_start(DIG_EMPTY);
        feed_block(1);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start_valid = 1'b1;
            ihs         = IV;
            w_valid     = 1'b1;
            w_main      = {$urandom, $urandom};
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || start_ready !== 1'b0 || w_ready !== 1'b0 || hash !== DIG_EMPTY) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d: got ov=%b sr=%b wr=%b hash=%h expected 1 0 0 %h",
                         i, out_valid, start_ready, w_ready, hash, DIG_EMPTY);
            end
            step();
        end
        w_valid   = 1'b0;
        out_ready = 1'b1;
        #1;
        n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %b expected 1", start_ready); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL hold_scoreboard: got empty queue expected entry"); end
        else begin
            if (hash !== exp_q[0]) begin n_fail++; $display("FAIL hold_hash: got %h expected %h", hash, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        exp_q.push_back(DIG_ABC);
        step();
        start_valid = 1'b0;
        out_ready   = 1'b0;
        n_tests++;
        if (w_ready !== 1'b1 || out_valid !== 1'b0 || round_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL hold_restart: got wr=%b ov=%b ri=%0d expected 1 0 0", w_ready, out_valid, round_idx);
        end
        feed_block(0);
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL hold2_scoreboard: got empty queue expected entry"); end
        else begin
            if (out_valid !== 1'b1 || hash !== exp_q[0]) begin
                n_fail++; $display("FAIL hold2_hash: got ov=%b %h expected 1 %h", out_valid, hash, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        do_start(DIG_EMPTY);
        feed_block(1);
        start_valid = 1'b1;
        ihs         = IV;
        #1;
        n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_start_ready: got %b expected 1", start_ready); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b1_scoreboard: got empty queue expected entry"); end
        else begin
            if (out_valid !== 1'b1 || hash !== exp_q[0]) begin
                n_fail++; $display("FAIL b2b1_hash: got ov=%b %h expected 1 %h", out_valid, hash, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        exp_q.push_back(DIG_ABC);
        step();
        start_valid = 1'b0;
        n_tests++;
        if (w_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_bubble: got wr=%b ov=%b expected 1 0", w_ready, out_valid);
        end
        feed_block(0);
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b2_scoreboard: got empty queue expected entry"); end
        else begin
            if (out_valid !== 1'b1 || hash !== exp_q[0]) begin
                n_fail++; $display("FAIL b2b2_hash: got ov=%b %h expected 1 %h", out_valid, hash, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || start_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle: got ov=%b sr=%b expected 0 1", out_valid, start_ready);
        end
    endtask

    task automatic test_reset_mid();
        start_valid = 1'b1;
        ihs         = IV;
        step();
        start_valid = 1'b0;
        for (int g = 0; g < 15; g++) begin
            w_valid = 1'b1;
            w_main  = {wsched[0][2*g+1], wsched[0][2*g]};
            step();
        end
        n_tests++; if (round_idx !== 6'd30) begin n_fail++; $display("FAIL mid_round: got %0d expected 30", round_idx); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (start_ready !== 1'b1 || w_ready !== 1'b0 || out_valid !== 1'b0 || hash !== 256'h0 || round_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_async_reset: got sr=%b wr=%b ov=%b ri=%0d hash=%h expected 1 0 0 0 0",
                     start_ready, w_ready, out_valid, round_idx, hash);
        end
        w_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        do_start(DIG_ABC);
        feed_block(0);
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL mid_scoreboard: got empty queue expected entry"); end
        else begin
            if (out_valid !== 1'b1 || hash !== exp_q[0]) begin
                n_fail++; $display("FAIL mid_fresh_hash: got ov=%b %h expected 1 %h", out_valid, hash, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        start_valid    = 1'b0;
        ihs            = '0;
        w_valid        = 1'b0;
        w_main         = '0;
        out_ready      = 1'b0;
        sw_start_valid = 1'b0;
        sw_w_valid     = 1'b0;
        sw_out_ready   = 1'b0;
        sw_grp         = 0;
        build_schedules();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_sweep();
        test_abc_main();
        test_stalls();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
